// File: rtl/load_store_unit.sv
// Load/store unit: sized, sign/zero-extended loads and byte/half/word stores to a byte-addressed word memory.
// Latency: error response 1 cycle, load or word store 2 cycles, byte/half store 3 cycles (read-modify-write).
// Backpressure: one request in flight; req_ready is low until a held response is taken with rsp_ready.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    // Only the low half of the store data is needed after acceptance:
    // a word store launches its write on the acceptance edge itself.
    logic [15:0]             wdata_q;

    logic [DATA_WIDTH-1:0]   load_ext;
    logic [DATA_WIDTH-1:0]   rmw_wd;

    assign mem_addr = addr_q;

    // Extend the captured read word and merge partial store data into it.
    always_comb begin
        load_ext = mem_rd;
        rmw_wd   = mem_rd;
        case (size_q)
            SZ_BYTE: begin
                load_ext = uns_q ? {24'd0, mem_rd[7:0]} : {{24{mem_rd[7]}}, mem_rd[7:0]};
                rmw_wd   = {mem_rd[31:8], wdata_q[7:0]};
            end
            SZ_HALF: begin
                load_ext = uns_q ? {16'd0, mem_rd[15:0]} : {{16{mem_rd[15]}}, mem_rd[15:0]};
                rmw_wd   = {mem_rd[31:16], wdata_q[15:0]};
            end
            default: begin
                load_ext = mem_rd;
                rmw_wd   = mem_rd;
            end
        endcase
    end

    // Request/response FSM with registered handshake and memory outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_we    <= 1'b0;
            mem_wd    <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            wdata_q   <= '0;
        end else begin
            // Write enable is a single-cycle pulse unless re-armed below.
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        wdata_q   <= req_wdata[15:0];
                        req_ready <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        if (req_size == SZ_ILLEGAL) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            state <= ACCESS;
                            // Word store needs no read: write during ACCESS.
                            if (req_we && req_size == SZ_WORD) begin
                                mem_we <= 1'b1;
                                mem_wd <= req_wdata;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rsp_rdata <= load_ext;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (size_q == SZ_WORD) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        // Partial store: keep untouched bytes from the read word.
                        mem_wd <= rmw_wd;
                        mem_we <= 1'b1;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte memory model, reference memory, per-cycle output checks.
// Expected response data, write words and timing come from a request-level model of the access rules.
// Exercises response backpressure, overlapping request during response, and reset mid-transaction.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory (the DUT's data memory) ----------------
    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] ma;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            'h10: init_byte = 8'h80;
            'h21: init_byte = 8'h34;
            'h22: init_byte = 8'hF2;
            'h40: init_byte = 8'h44;
            'h41: init_byte = 8'h33;
            'h42: init_byte = 8'h22;
            'h43: init_byte = 8'h11;
            default: init_byte = 8'(i) ^ 8'h5A;
        endcase
    endfunction

    assign ma     = mem_addr[7:0];
    assign mem_rd = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (mem_we)
                for (int i = 0; i < 4; i++) mem[ma + 8'(i)] = mem_wd[8*i +: 8];
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expectations for the request in flight.
    bit          chk_en = 1'b0;
    bit          active = 1'b0;
    int          e_t, e_lat, e_welat;
    logic [31:0] e_rdata, e_wd, e_addr;
    logic        e_err;

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        ref_word = {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
    endfunction

    // Request-level model: response value, write word and timing from the access rules.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit commit);
        int          nb;
        logic [31:0] word, mask, v;
        e_addr = addr;
        e_err  = (size == 2'b11);
        word   = ref_word(addr[7:0]);
        nb     = (size == 2'b11) ? 0 : (1 << size);
        mask   = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        if (e_err) begin
            e_lat = 1; e_welat = 0; e_rdata = 0; e_wd = 0;
        end else if (!we) begin
            e_lat = 2; e_welat = 0; e_wd = 0;
            v = word & mask;
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
            e_rdata = v;
        end else begin
            e_lat   = (nb == 4) ? 2 : 3;
            e_welat = (nb == 4) ? 1 : 2;
            e_rdata = 0;
            e_wd    = word;
            for (int i = 0; i < nb; i++) e_wd[8*i +: 8] = wdata[8*i +: 8];
            if (commit)
                for (int i = 0; i < nb; i++) ref_mem[addr[7:0] + 8'(i)] = wdata[8*i +: 8];
        end
    endtask

    // Per-cycle compare against the model, sampled 2 time units after each rising edge.
    initial begin
        bit ev, ew;
        forever begin
            @(posedge clk);
            #2;
            if (chk_en) begin
                if (active) begin
                    ev = (cyc >= e_t + e_lat - 1);
                    ew = (e_welat != 0) && (cyc == e_t + e_welat - 1);
                    chk("rsp_valid", rsp_valid, ev);
                    chk("req_ready_busy", req_ready, 0);
                    chk("mem_we", mem_we, ew);
                    chk("mem_addr", mem_addr, e_addr);
                    if (ev) begin
                        chk("rsp_rdata", rsp_rdata, e_rdata);
                        chk("rsp_err", rsp_err, e_err);
                    end
                    if (ew) chk("mem_wd", mem_wd, e_wd);
                end else begin
                    chk("idle_rsp_valid", rsp_valid, 0);
                    chk("idle_req_ready", req_ready, 1);
                    chk("idle_mem_we", mem_we, 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic present(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        e_t = cyc + 1;
        active = 1;
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input bit overlap,
                          output logic [31:0] got_rdata, output logic got_err);
        int n;
        model(we, size, uns, addr, wdata, 1'b1);
        present(we, size, uns, addr, wdata);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
        repeat (hold) @(negedge clk);
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        rsp_ready = 1;
        if (overlap) begin
            // A request offered in the consume cycle must not be taken.
            req_valid = 1; req_we = 0; req_size = 2'b10; req_addr = 32'h0;
        end
        @(posedge clk);
        active = 0;
        #1 rsp_ready = 0;
        req_valid = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_err"},   rsp_err, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_mem_we"},    mem_we, 0);
        chk({tag, "_mem_wd"},    mem_wd, 0);
        chk({tag, "_mem_addr"},  mem_addr, 0);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        reset = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        check_reset_vals("reset");
        chk_en = 1;

        // Signed byte load of 0x80.
        do_req(0, 2'b00, 0, 32'h10, 0, 0, 0, r, e);
        chk("lit_lb_signed", r, 32'hFFFF_FF80);
        // Unsigned half load at odd address.
        do_req(0, 2'b01, 1, 32'h21, 0, 0, 0, r, e);
        chk("lit_lhu_unaligned", r, 32'h0000_F234);
        // Byte store read-modify-write; upper store bits must be ignored.
        do_req(1, 2'b00, 0, 32'h40, 32'hCCCC_CCAB, 0, 0, r, e);
        chk("lit_sb_rdata", r, 0);
        chk("lit_sb_memword", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h1122_33AB);
        do_req(0, 2'b10, 0, 32'h40, 0, 0, 0, r, e);
        chk("lit_lw_after_sb", r, 32'h1122_33AB);
        // Word store then read back.
        do_req(1, 2'b10, 0, 32'h08, 32'hDEAD_BEEF, 0, 0, r, e);
        chk("lit_sw_rdata", r, 0);
        do_req(0, 2'b10, 0, 32'h08, 0, 0, 0, r, e);
        chk("lit_lw_after_sw", r, 32'hDEAD_BEEF);
        // Illegal size, as a store and as a load.
        do_req(1, 2'b11, 0, 32'h30, 32'h1234_5678, 0, 0, r, e);
        chk("lit_illegal_err", e, 1);
        chk("lit_illegal_mem", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]},
            {init_byte('h33), init_byte('h32), init_byte('h31), init_byte('h30)});
        do_req(0, 2'b11, 1, 32'h10, 0, 2, 0, r, e);
        chk("lit_illegal_ld_rdata", r, 0);
        // More extension cases and an unaligned word load.
        do_req(0, 2'b01, 0, 32'h21, 0, 0, 0, r, e);
        chk("lit_lh_signed", r, 32'hFFFF_F234);
        do_req(0, 2'b00, 1, 32'h10, 0, 0, 0, r, e);
        chk("lit_lbu", r, 32'h0000_0080);
        do_req(0, 2'b10, 0, 32'h21, 0, 0, 0, r, e);
        chk("lit_lw_unaligned", r, 32'h7E79_F234);
        // Half store with 5 cycles of backpressure and an overlapping request.
        do_req(1, 2'b01, 0, 32'h21, 32'hABCD_5566, 5, 1, r, e);
        do_req(0, 2'b10, 0, 32'h20, 0, 0, 0, r, e);
        chk("lit_lw_after_sh", r, 32'h7955_667A);

        // Reset while a load is in ACCESS: no response may appear.
        model(0, 2'b00, 0, 32'h10, 0, 1'b0);
        present(0, 2'b00, 0, 32'h10, 0);
        @(negedge clk);
        reset = 1; active = 0;
        @(negedge clk);
        reset = 0;
        check_reset_vals("rst_access");
        repeat (3) @(negedge clk);

        // Reset while a byte store is in WRITE.
        model(1, 2'b00, 0, 32'h80, 32'h0000_0077, 1'b0);
        present(1, 2'b00, 0, 32'h80, 32'h0000_0077);
        @(negedge clk);
        @(negedge clk);
        chk("rst_write_we_before", mem_we, 1);
        reset = 1; active = 0;
        @(negedge clk);
        reset = 0;
        check_reset_vals("rst_write");
        repeat (3) @(negedge clk);

        // Normal operation resumes after reset.
        do_req(0, 2'b00, 0, 32'h10, 0, 0, 0, r, e);
        chk("lit_lb_after_reset", r, 32'hFFFF_FF80);

        repeat (2) @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the width of the byte address.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the word width; it SHALL be fixed at 32 (4 bytes).
REQ-003 SHALL use one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-004 SHALL have port: clk  input  1  system clock.
REQ-005 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port: req_valid  input  1  the processor presents a request.
REQ-007 SHALL have port: req_ready  output  1  the unit accepts a request this cycle.
REQ-008 SHALL have port: req_we  input  1  1 selects a store, 0 selects a load.
REQ-009 SHALL have port: req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port: req_unsigned  input  1  on a load, 1 selects zero-extension and 0 selects sign-extension.
REQ-011 SHALL have port: req_addr  input  ADDR_WIDTH  byte address.
REQ-012 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-013 SHALL have port: rsp_valid  output  1  a response is held.
REQ-014 SHALL have port: rsp_ready  input  1  the processor consumes the response.
REQ-015 SHALL have port: rsp_rdata  output  32  extended load data, or 0 for a store or an error.
REQ-016 SHALL have port: rsp_err  output  1  the request had illegal size.
REQ-017 SHALL have port: mem_addr  output  ADDR_WIDTH  address to the data memory.
REQ-018 SHALL have port: mem_we  output  1  write enable to the data memory.
REQ-019 SHALL have port: mem_wd  output  32  write word; byte i is written to mem_addr+i.
REQ-020 SHALL have port: mem_rd  input  32  combinational read word; byte i comes from mem_addr+i, little-endian.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP.
REQ-022 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid && req_ready, and all request fields SHALL be registered on acceptance.
REQ-023 SHALL handle IDLE on acceptance as follows: req_size=11 goes to RESP with rsp_err=1 and no memory access; any other size goes to ACCESS.
REQ-024 SHALL drive mem_addr from the registered address in every state; mem_we SHALL be 1 only as stated in REQ-026 and REQ-027.
REQ-025 SHALL handle a load in ACCESS as follows: capture mem_rd; byte uses bits [7:0] and half uses bits [15:0]; the value is extended per req_unsigned (word unchanged) into rsp_rdata; the next state is RESP.
REQ-026 SHALL handle a word store in ACCESS as follows: mem_we=1 and mem_wd=wdata for exactly that cycle, then go to RESP.
REQ-027 SHALL perform a byte or half store as a read-modify-write: in ACCESS, capture mem_rd and go to WRITE; in WRITE, mem_we=1 for one cycle with mem_wd={rd[31:8],wdata[7:0]} (byte) or {rd[31:16],wdata[15:0]} (half), then go to RESP.
REQ-028 SHALL hold rsp_valid=1 in RESP, with rsp_rdata and rsp_err stable, until rsp_ready=1; it SHALL then go to IDLE with rsp_valid deasserted the next cycle.
REQ-029 SHALL have the following latency from the acceptance edge T: load, word store, or error gives rsp_valid at T+2 (T+1 for an error); byte or half store gives rsp_valid at T+3.
REQ-030 SHALL treat unaligned addresses as legal and pass them unchanged, since the memory spans bytes addr..addr+3; address wrap-around SHALL be the memory's concern.
REQ-031 SHALL NOT accept a new request while rsp_valid=1, even when rsp_ready=1 in the same cycle.
REQ-032 SHALL set rsp_rdata=0 for stores and errors.

Reset
REQ-033 SHALL, on reset, force state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_wd=0, and all registered request fields (including mem_addr) to 0.
REQ-034 SHALL, on reset asserted in ACCESS or WRITE, issue no mem_we on the following cycle and discard any pending response.

Verification
REQ-035 SHALL cover a signed byte load: memory at 0x10 holds 0x80; load byte, signed, addr 0x10 -> rsp_rdata=0xFFFFFF80 at T+2.
REQ-036 SHALL cover an unsigned half load: bytes at 0x21..0x22 are 0x34,0xF2; load half, unsigned, addr 0x21 -> rsp_rdata=0x0000F234.
REQ-037 SHALL cover a byte store RMW: word at 0x40 is 0x11223344; store byte 0xAB -> one mem_we pulse at T+2 with mem_wd=0x112233AB; a subsequent word load returns 0x112233AB.
REQ-038 SHALL cover a word store: store word 0xDEADBEEF at 0x8 -> mem_we high only at T+1; rsp_valid at T+2; rsp_rdata=0.
REQ-039 SHALL cover an illegal size: req_size=11 -> rsp_err=1 at T+1; no mem_we in any cycle.
REQ-040 SHALL cover backpressure and reset: with rsp_ready=0 for 5 cycles, rsp_valid and data hold and req_ready=0; reset asserted in WRITE -> mem_we=0 on the next edge, and all outputs return to their reset values.
